uart_string_tx: RTL
===================

Name: uart_string_tx

Overview:
Parametrised serial string transmitter. It snapshots a packed ASCII string and a runtime length, then emits the characters back-to-back as 8N1 UART frames on a single tx line. The baud generator and shift register are built in, so no external tx instance is needed. It sits between message-generation logic and the board UART pin, and adds runtime length, a configurable baud rate, busy status and a character index.

Parameters:
MAX_CHARS, 16, capacity of string_in in characters (>=1)
CLK_FREQ, 100000000, clock frequency in Hz
BAUD_RATE, 19200, line rate in bits/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer, >=2)
LW, $clog2(MAX_CHARS+1), width of length/char_idx (localparam)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  level request to send; sampled only in IDLE and DONE
length  input  LW  number of characters to send, latched with string_in
string_in  input  MAX_CHARS*8  packed string; character 0 = bits [MAX_CHARS*8-1 -: 8]
busy  output  1  high from launch until last stop bit completes
done  output  1  high in DONE state
char_idx  output  LW  index of character currently on the line
tx  output  1  serial out, idle high

Behaviour:
- Reset (async) values: state=IDLE, tx=1, busy=0, done=0, char_idx=0, baud counter=0, bit counter=0. Reset asserted mid-frame forces tx=1 immediately; the partial frame is abandoned.
- States: IDLE, START, DATA, STOP, DONE.
- IDLE: tx=1. When enable=1 at a clock edge:
  - latch string_in into shadow register;
  - latch len = min(length, MAX_CHARS);
  - char_idx<=0.
  - If len==0, go to DONE; otherwise go to START, busy<=1.
  - tx falls on the first cycle after the sampling edge (1-cycle latency).
- START: tx=0 for BAUD_DIV cycles, then go to DATA with bit counter=0.
- DATA: tx = current character bit[bitcnt], LSB first, each bit held BAUD_DIV cycles. After bit 7, go to STOP.
- STOP: tx=1 for BAUD_DIV cycles. At the end of the stop bit:
  - if char_idx==len-1, go to DONE and busy<=0;
  - otherwise char_idx increments and go to START. There is no idle gap between frames.
- Frame = 10*BAUD_DIV cycles. A whole string takes len*10*BAUD_DIV cycles from the first start bit to the end of the last stop bit.
- DONE: done=1, busy=0, tx=1. Stays in DONE while enable=1, returns to IDLE the cycle after enable is seen low. done is high for at least 1 cycle.
- enable changes while busy are ignored. string_in/length changes after launch have no effect (shadowed).
- Baud counter: counts 0..BAUD_DIV-1, wraps at terminal count, and clears on every state entry from IDLE.
- length > MAX_CHARS is clamped to MAX_CHARS, with no error flag.

Optional Feature:
UART_PARITY_EN:
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted after DATA via an extra PARITY state, BAUD_DIV cycles long. Frame = 11*BAUD_DIV cycles.
- Undefined: no PARITY state and 10-bit frames; the RTL for the state is excluded entirely.

Test Plan:
- CLK_FREQ=100, BAUD_RATE=10 (BAUD_DIV=10), length=1, char 0x41, enable pulse held -> tx low at cycle 1 for 10 cycles, then data 1,0,0,0,0,0,1,0, then high. done rises at cycle 101; busy is high for cycles 1-100.
- length=2, string "Hi" (0x48,0x69) -> two back-to-back frames over 200 cycles. char_idx=0 then 1. The second start bit immediately follows the first stop bit.
- length=0, enable=1 -> DONE on the next cycle, tx stays 1, busy never asserts; dropping enable -> IDLE one cycle later.
- length=20 with MAX_CHARS=16 -> exactly 16 frames sent; string_in changed mid-transmission -> original bytes still sent.
- Reset asserted at cycle 45 of a frame -> tx=1, busy=0, done=0 asynchronously. After release with enable=0 the block stays IDLE and tx stays 1.
- UART_PARITY_EN defined, char 0x41 (two 1s) -> parity bit 0 and an 11-bit frame of 110 cycles; char 0x43 -> parity bit 1.

Source files
------------

// File: rtl/uart_string_tx.sv
// Serial string transmitter: latches a packed ASCII string and a length, then sends the characters back-to-back as UART frames.
// Define UART_PARITY_EN to add an even-parity bit after the data bits (11-bit frames).
module uart_string_tx #(
    parameter int MAX_CHARS = 16,
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 19200,
    localparam int LW       = $clog2(MAX_CHARS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [LW-1:0]          length,
    input  logic [MAX_CHARS*8-1:0] string_in,
    output logic                   busy,
    output logic                   done,
    output logic [LW-1:0]          char_idx,
    output logic                   tx
);

    localparam int             BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int             BW       = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]  BAUD_TC  = BW'(BAUD_DIV - 1);
    localparam logic [LW-1:0]  MAX_LEN  = LW'(MAX_CHARS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [BW-1:0]          r_baud_cnt;
    logic [2:0]             r_bitcnt;
    logic [2:0]             w_bitcnt_next;
    logic [LW-1:0]          r_char_idx;
    logic [LW-1:0]          w_idx_next;
    logic [LW-1:0]          r_len;
    logic [LW-1:0]          w_len_clamped;
    logic [MAX_CHARS*8-1:0] r_shadow;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   w_launch;
    logic                   w_baud_tc;
    logic                   w_active;
    logic [7:0]             w_cur_char;

    assign w_baud_tc     = (r_baud_cnt == BAUD_TC);
    assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_active      = (r_state != S_IDLE) && (r_state != S_DONE);

    assign busy     = w_active;
    assign done     = (r_state == S_DONE);
    assign char_idx = r_char_idx;
    assign tx       = r_tx;

    // Character 0 occupies the most significant byte of the shadow register.
    always_comb begin
        w_cur_char = '0;
        for (int unsigned k = 0; k < MAX_CHARS; k++) begin
            if (r_char_idx == LW'(k)) begin
                w_cur_char = r_shadow[(MAX_CHARS-1-k)*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_bitcnt_next = r_bitcnt;
        w_idx_next    = r_char_idx;
        w_launch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_launch     = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = (w_len_clamped == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                if (w_baud_tc) begin
                    w_state_next  = S_DATA;
                    w_bitcnt_next = '0;
                end
            end
            S_DATA: begin
                if (w_baud_tc) begin
                    if (r_bitcnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bitcnt_next = r_bitcnt + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_baud_tc) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_tc) begin
                    if (r_char_idx == r_len - LW'(1)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_idx_next   = r_char_idx + LW'(1);
                        w_state_next = S_START;
                    end
                end
            end
            S_DONE: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The line level is computed from the next state so tx comes straight from a flop.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_cur_char[w_bitcnt_next];
`ifdef UART_PARITY_EN
            S_PARITY: w_tx_next = ^w_cur_char;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_bitcnt   <= '0;
            r_baud_cnt <= '0;
            r_char_idx <= '0;
            r_len      <= '0;
            r_shadow   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tx       <= w_tx_next;
            r_bitcnt   <= w_bitcnt_next;
            r_char_idx <= w_idx_next;
            if (w_launch) begin
                r_shadow <= string_in;
                r_len    <= w_len_clamped;
            end
            if (w_active && !w_baud_tc) begin
                r_baud_cnt <= r_baud_cnt + BW'(1);
            end else begin
                r_baud_cnt <= '0;
            end
        end
    end

endmodule
